// File: rtl/axis_frame_arbiter_pkg.sv
// Shared definitions for the AXI-stream frame arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / ACTIVE)
//   idx_w()     : width of a port index for a given port count
package axis_frame_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    localparam int MIN_PORTS = 2;
    localparam int MAX_PORTS = 16;

    // Index width derived from the port count; never narrower than one bit.
    function automatic int idx_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_select.sv
// Combinational round-robin selector.
//   req_i       : request vector, one bit per port
//   last_i      : index of the most recently served port
//   grant_oh_o  : one-hot of the first requester after last_i (wrapping)
//   grant_idx_o : binary index of that requester
//   grant_vld_o : at least one request present
module axis_rr_select
    import axis_frame_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = idx_w(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [PORTS-1:0] grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    logic [IDX_W-1:0] cand;

    // Scan from last_i+1 around to last_i itself; the first hit wins, so a
    // lone requester is granted even when it was served last.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = IDX_W'((int'(last_i) + k) % PORTS);
            if (!grant_vld_o && req_i[cand]) begin
                grant_vld_o      = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Round-robin AXI-stream frame arbiter: PORTS inputs to one output, whole
// frames only, registered output with a one-entry skid buffer.
//   clk, rst                 : clock, asynchronous active-high reset
//   input_axis_t*            : PORTS packed input streams (port i = slice i)
//   output_axis_t*           : merged output stream
//   grant_valid, grant_index : a frame is granted / which port owns it
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   input_axis_tkeep,
    input  logic [PORTS-1:0]              input_axis_tvalid,
    output logic [PORTS-1:0]              input_axis_tready,
    input  logic [PORTS-1:0]              input_axis_tlast,
    input  logic [PORTS-1:0]              input_axis_tuser,
    output logic [DATA_WIDTH-1:0]         output_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
    output logic                          output_axis_tvalid,
    input  logic                          output_axis_tready,
    output logic                          output_axis_tlast,
    output logic                          output_axis_tuser,
    output logic                          grant_valid,
    output logic [idx_w(PORTS)-1:0]       grant_index
);

    localparam int IDX_W = idx_w(PORTS);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_index_q, grant_index_d;
    logic [PORTS-1:0] grant_oh_q, grant_oh_d;
    logic             grant_valid_q, grant_valid_d;
    logic             ready_int_q;

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, tmp_data_q, tmp_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d, tmp_keep_q, tmp_keep_d;
    logic out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
    logic out_last_q, out_last_d, tmp_last_q, tmp_last_d;
    logic out_user_q, out_user_d, tmp_user_q, tmp_user_d;

    logic [PORTS-1:0] rr_oh;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_vld;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic sel_valid, sel_last, sel_user;
    logic beat_valid, early_ready;

    axis_rr_select #(.PORTS(PORTS), .IDX_W(IDX_W)) u_rr_select (
        .req_i       (input_axis_tvalid),
        .last_i      (last_grant_q),
        .grant_oh_o  (rr_oh),
        .grant_idx_o (rr_idx),
        .grant_vld_o (rr_vld)
    );

    // Granted-port mux.
    assign sel_data  = input_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep  = input_axis_tkeep[grant_index_q*KEEP_WIDTH +: KEEP_WIDTH];
    assign sel_valid = input_axis_tvalid[grant_index_q];
    assign sel_last  = input_axis_tlast[grant_index_q];
    assign sel_user  = input_axis_tuser[grant_index_q];

    // A beat is accepted only in ACTIVE while the registered ready is high.
    assign beat_valid  = (state_q == ST_ACTIVE) && ready_int_q && sel_valid;
    // Ready for next cycle: space is guaranteed if the sink drains or the skid
    // stays empty and the output register is free or not being refilled.
    assign early_ready = output_axis_tready ||
                         (!tmp_valid_q && (!out_valid_q || !beat_valid));

    always_comb begin
        input_axis_tready = '0;
        if (state_q == ST_ACTIVE) begin
            input_axis_tready = grant_oh_q & {PORTS{ready_int_q}};
        end
    end

    // Arbiter FSM next state.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_index_d = grant_index_q;
        grant_oh_d    = grant_oh_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_vld) begin
                    grant_index_d = rr_idx;
                    grant_oh_d    = rr_oh;
                    grant_valid_d = 1'b1;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (beat_valid && sel_last) begin
                    last_grant_d  = grant_index_q;
                    grant_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register plus skid buffer. Data is captured even when the
    // written valid is 0; that is harmless because valid qualifies it.
    always_comb begin
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        out_valid_d = out_valid_q;
        tmp_data_d  = tmp_data_q;
        tmp_keep_d  = tmp_keep_q;
        tmp_last_d  = tmp_last_q;
        tmp_user_d  = tmp_user_q;
        tmp_valid_d = tmp_valid_q;
        if (ready_int_q) begin
            if (output_axis_tready || !out_valid_q) begin
                out_data_d  = sel_data;
                out_keep_d  = sel_keep;
                out_last_d  = sel_last;
                out_user_d  = sel_user;
                out_valid_d = beat_valid;
            end else begin
                tmp_data_d  = sel_data;
                tmp_keep_d  = sel_keep;
                tmp_last_d  = sel_last;
                tmp_user_d  = sel_user;
                tmp_valid_d = beat_valid;
            end
        end else if (output_axis_tready) begin
            out_data_d  = tmp_data_q;
            out_keep_d  = tmp_keep_q;
            out_last_d  = tmp_last_q;
            out_user_d  = tmp_user_q;
            out_valid_d = tmp_valid_q;
            tmp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= IDX_W'(PORTS - 1);
            grant_index_q <= '0;
            grant_oh_q    <= '0;
            grant_valid_q <= 1'b0;
            ready_int_q   <= 1'b0;
            out_data_q    <= '0;
            out_keep_q    <= '0;
            out_last_q    <= 1'b0;
            out_user_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            tmp_data_q    <= '0;
            tmp_keep_q    <= '0;
            tmp_last_q    <= 1'b0;
            tmp_user_q    <= 1'b0;
            tmp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_index_q <= grant_index_d;
            grant_oh_q    <= grant_oh_d;
            grant_valid_q <= grant_valid_d;
            ready_int_q   <= early_ready;
            out_data_q    <= out_data_d;
            out_keep_q    <= out_keep_d;
            out_last_q    <= out_last_d;
            out_user_q    <= out_user_d;
            out_valid_q   <= out_valid_d;
            tmp_data_q    <= tmp_data_d;
            tmp_keep_q    <= tmp_keep_d;
            tmp_last_q    <= tmp_last_d;
            tmp_user_q    <= tmp_user_d;
            tmp_valid_q   <= tmp_valid_d;
        end
    end

    assign output_axis_tdata  = out_data_q;
    assign output_axis_tkeep  = out_keep_q;
    assign output_axis_tlast  = out_last_q;
    assign output_axis_tuser  = out_user_q;
    assign output_axis_tvalid = out_valid_q;
    assign grant_valid        = grant_valid_q;
    assign grant_index        = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Testbench for axis_frame_arbiter (PORTS=4, DATA_WIDTH=64).
// A frame-level round-robin reference model predicts the grant order and the
// exact output beat sequence; per-cycle checks compare the DUT against it.
module tb_axis_frame_arbiter;

    localparam int P  = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [1:0]  gap;
    } beat_t;

    logic            clk;
    logic            rst;
    logic [P*DW-1:0] in_tdata;
    logic [P*KW-1:0] in_tkeep;
    logic [P-1:0]    in_tvalid, in_tready, in_tlast, in_tuser;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic            out_tvalid, out_tready, out_tlast, out_tuser;
    logic            grant_valid;
    logic [1:0]      grant_index;

    axis_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_axis_tdata   (in_tdata),
        .input_axis_tkeep   (in_tkeep),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .input_axis_tlast   (in_tlast),
        .input_axis_tuser   (in_tuser),
        .output_axis_tdata  (out_tdata),
        .output_axis_tkeep  (out_tkeep),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .output_axis_tlast  (out_tlast),
        .output_axis_tuser  (out_tuser),
        .grant_valid        (grant_valid),
        .grant_index        (grant_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    beat_t    pq[P][$];     // beats still to be driven per port
    beat_t    hist[P][$];   // every beat loaded per port (model input)
    int       bidx[P];      // next unmodelled beat per port
    int       hold[P];      // idle cycles before presenting front beat
    int       acc_cnt[P];
    logic [P-1:0] acc;
    beat_t    exp_q[$];
    int       exp_g[$];
    int       mdl_last;
    int       cur_grant;
    int       stall_cnt;
    bit       rand_rdy;
    bit       chk_idle;
    bit       seen_grant;
    logic     prev_gv;
    int       idle_run;
    int       n_out;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level round robin over the frames loaded since the last call.
    task automatic model_build();
        int rem[P];
        int p;
        int guard;
        for (int q = 0; q < P; q++) begin
            rem[q] = 0;
            for (int i = bidx[q]; i < hist[q].size(); i++)
                if (hist[q][i].last) rem[q]++;
        end
        guard = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && guard < 1000) begin
            guard++;
            p = -1;
            for (int k = 1; k <= P; k++)
                if (p < 0 && rem[(mdl_last + k) % P] > 0) p = (mdl_last + k) % P;
            exp_g.push_back(p);
            do begin
                exp_q.push_back(hist[p][bidx[p]]);
                bidx[p]++;
            end while (!hist[p][bidx[p]-1].last);
            rem[p]--;
            mdl_last = p;
        end
    endtask

    task automatic load_frame(input int p, input int n, input logic [63:0] base,
                              input bit rnd, input int gap_at, input int gap_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = rnd ? {$urandom(), $urandom()} : base + 64'(i);
            b.keep = rnd ? 8'($urandom()) : 8'hFF;
            b.last = (i == n - 1);
            b.user = rnd ? 1'($urandom()) : (i == 1);
            if (i == 0)          b.gap = 2'd0;
            else if (rnd)        b.gap = 2'($urandom_range(0, 2));
            else if (i == gap_at) b.gap = 2'(gap_len);
            else                 b.gap = 2'd0;
            pq[p].push_back(b);
            hist[p].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int p = 0; p < P; p++) begin
            if (pq[p].size() == 0 || hold[p] > 0) begin
                if (hold[p] > 0) hold[p]--;
                in_tvalid[p]           = 1'b0;
                in_tdata[p*DW +: DW]   = '0;
                in_tkeep[p*KW +: KW]   = '0;
                in_tlast[p]            = 1'b0;
                in_tuser[p]            = 1'b0;
            end else begin
                in_tvalid[p]           = 1'b1;
                in_tdata[p*DW +: DW]   = pq[p][0].data;
                in_tkeep[p*KW +: KW]   = pq[p][0].keep;
                in_tlast[p]            = pq[p][0].last;
                in_tuser[p]            = pq[p][0].user;
            end
        end
        if (stall_cnt > 0) begin
            out_tready = 1'b0;
            stall_cnt--;
        end else begin
            out_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic cycle();
        beat_t        b;
        logic [P-1:0] mask;
        drive_inputs();
        @(negedge clk);
        mask = grant_valid ? (P'(1) << grant_index) : '0;
        check("tready_mask", in_tready & ~mask, 0);
        acc = in_tvalid & in_tready;
        if (out_tvalid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", out_tvalid, 0);
            end else begin
                b = exp_q[0];
                check("out_beat", {out_tdata, out_tkeep, out_tlast, out_tuser},
                      {b.data, b.keep, b.last, b.user});
                if (out_tready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (grant_valid && !prev_gv) begin
            if (exp_g.size() == 0) begin
                check("spurious_grant", grant_valid, 0);
            end else begin
                cur_grant = exp_g.pop_front();
                check("grant_index", grant_index, cur_grant);
                if (chk_idle && seen_grant) check("idle_gap", idle_run, 1);
            end
            seen_grant = 1'b1;
            idle_run   = 0;
        end else if (grant_valid) begin
            check("grant_hold", grant_index, cur_grant);
        end else begin
            idle_run++;
        end
        prev_gv = grant_valid;
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            if (acc[p]) begin
                void'(pq[p].pop_front());
                acc_cnt[p]++;
                hold[p] = (pq[p].size() > 0) ? int'(pq[p][0].gap) : 0;
            end
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_tkeep", out_tkeep, 0);
        check("rst_out_tlast", out_tlast, 0);
        check("rst_out_tuser", out_tuser, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_index", grant_index, 0);
        check("rst_in_tready", in_tready, 0);
        for (int p = 0; p < P; p++) begin
            pq[p].delete();
            hist[p].delete();
            bidx[p] = 0;
            hold[p] = 0;
        end
        exp_q.delete();
        exp_g.delete();
        mdl_last   = P - 1;
        stall_cnt  = 0;
        rand_rdy   = 1'b0;
        chk_idle   = 1'b0;
        seen_grant = 1'b0;
        prev_gv    = 1'b0;
        idle_run   = 0;
        in_tvalid  = '0;
        out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_g.size() != 0 ||
                pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check("beats_left", exp_q.size(), 0);
        check("grants_left", exp_g.size(), 0);
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (n_out < target && n < budget) begin
            cycle();
            n++;
        end
        check("wait_out", n_out >= target, 1);
    endtask

    task automatic wait_acc(input int p, input int target, input int budget);
        int n = 0;
        while (acc_cnt[p] < target && n < budget) begin
            cycle();
            n++;
        end
        check("wait_acc", acc_cnt[p] >= target, 1);
    endtask

    initial begin
        int start;
        rst        = 1'b0;
        in_tdata   = '0;
        in_tkeep   = '0;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tuser   = '0;
        out_tready = 1'b1;
        n_out      = 0;
        cur_grant  = 0;
        for (int p = 0; p < P; p++) acc_cnt[p] = 0;
        do_reset();

        // Ports 0 and 2 each with a 3-beat frame: port 0 first.
        load_frame(0, 3, 64'h0000_0000_0000_0100, 1'b0, -1, 0);
        load_frame(2, 3, 64'h0000_0000_0000_0300, 1'b0, -1, 0);
        model_build();
        drain(200);

        // All ports streaming 1-beat frames: 0,1,2,3,0,... one idle cycle apart.
        do_reset();
        chk_idle = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < P; p++)
                load_frame(p, 1, 64'h1000 + 64'(r * 16 + p), 1'b0, -1, 0);
        model_build();
        drain(200);
        chk_idle = 1'b0;

        // 8-beat frame, data 0..7, sink stalls 5 cycles mid-frame.
        load_frame(2, 8, 64'h0, 1'b0, -1, 0);
        model_build();
        start = n_out;
        wait_out(start + 2, 100);
        stall_cnt = 5;
        drain(200);

        // Port 3 requests while port 1 is mid-frame.
        load_frame(1, 8, 64'h3400, 1'b0, -1, 0);
        model_build();
        wait_acc(1, acc_cnt[1] + 2, 100);
        load_frame(3, 3, 64'h3700, 1'b0, -1, 0);
        model_build();
        drain(200);

        // Granted port goes quiet for 3 cycles before its fourth beat.
        load_frame(0, 6, 64'h3500, 1'b0, 3, 3);
        model_build();
        drain(200);

        // Randomized frames, gaps and backpressure.
        rand_rdy = 1'b1;
        for (int round = 0; round < 4; round++) begin
            for (int p = 0; p < P; p++) begin
                int nf = $urandom_range(0, 2);
                for (int f = 0; f < nf; f++)
                    load_frame(p, $urandom_range(1, 6), 64'h0, 1'b1, -1, 0);
            end
            model_build();
            drain(2000);
        end
        rand_rdy = 1'b0;

        // Reset during beat 2 of a 5-beat frame on port 1 (after a 1-beat
        // port-1 frame so the pre-reset last grant is 1).
        load_frame(1, 1, 64'h3600, 1'b0, -1, 0);
        load_frame(1, 5, 64'h3610, 1'b0, -1, 0);
        model_build();
        wait_acc(1, acc_cnt[1] + 2, 100);
        drive_inputs();
        do_reset();
        load_frame(1, 3, 64'h3810, 1'b0, -1, 0);
        load_frame(0, 3, 64'h3800, 1'b0, -1, 0);
        load_frame(3, 3, 64'h3830, 1'b0, -1, 0);
        model_build();
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
